// File: rtl/pdm_modulator.sv
`default_nettype none
// ============================================================================
// Module   : pdm_modulator
// Function : First-order sigma-delta PDM transmitter with a one-deep sample
//            hold register and generated PDM bit clock.
// Revision : 1.0 - initial release
// ============================================================================
module pdm_modulator #(
    parameter int CLK_DIV = 32,
    parameter int OSR     = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        pdm_clk,
    output logic        pdm_out,
    output logic        bit_strobe,
    output logic        frame_strobe,
    output logic        underrun,
    output logic [15:0] underrun_count
);

    localparam int c_DIV_W = $clog2(CLK_DIV);
    localparam int c_BIT_W = $clog2(OSR);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_HALF = c_DIV_W'(CLK_DIV / 2);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(OSR - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_PRIME = 2'd1;
    localparam logic [1:0] c_ST_RUN   = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_DIV_W-1:0] r_div_cnt;
    logic [c_BIT_W-1:0] r_bit_cnt;
    logic [15:0]        r_acc;
    logic [15:0]        r_active;
    logic [15:0]        r_hold;
    logic               r_hold_full;
    logic               r_pdm_clk;
    logic               r_pdm_out;
    logic               r_bit_strobe;
    logic [15:0]        r_underrun_count;

    logic               w_running;
    logic               w_boundary;
    logic               w_load;
    logic               w_underrun;
    logic               w_ready;
    logic               w_accept;
    logic [c_DIV_W-1:0] w_div_next;
    logic [15:0]        w_next_active;
    logic [15:0]        w_u;
    logic [16:0]        w_sum;

    assign w_running  = en && (r_state != c_ST_IDLE);
    assign w_boundary = w_running && (r_div_cnt == c_DIV_LAST);
    assign w_load     = w_boundary && (r_bit_cnt == c_BIT_LAST);
    assign w_underrun = w_load && (r_state == c_ST_RUN) && !r_hold_full;
    assign w_ready    = (r_state != c_ST_IDLE) && !r_hold_full;
    assign w_accept   = sample_valid && w_ready;
    assign w_div_next = (r_div_cnt == c_DIV_LAST) ? '0 : r_div_cnt + c_DIV_W'(1);

    // A freshly loaded sample already drives the bit emitted on the load edge.
    assign w_next_active = w_load ? (r_hold_full ? r_hold : 16'd0) : r_active;
    assign w_u           = {~w_next_active[15], w_next_active[14:0]};
    assign w_sum         = {1'b0, r_acc} + {1'b0, w_u};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (en) w_state_next = c_ST_PRIME;
            end
            c_ST_PRIME: begin
                if (!en)                        w_state_next = c_ST_IDLE;
                else if (w_load && r_hold_full) w_state_next = c_ST_RUN;
            end
            c_ST_RUN: begin
                if (!en) w_state_next = c_ST_IDLE;
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= c_ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_acc        <= '0;
            r_active     <= '0;
            r_hold       <= '0;
            r_hold_full  <= 1'b0;
            r_pdm_clk    <= 1'b0;
            r_pdm_out    <= 1'b0;
            r_bit_strobe <= 1'b0;
        end else if (!w_running) begin
            // Leaving or sitting in IDLE discards any partial frame and held sample.
            r_div_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_acc        <= '0;
            r_active     <= '0;
            r_hold       <= '0;
            r_hold_full  <= 1'b0;
            r_pdm_clk    <= 1'b0;
            r_pdm_out    <= 1'b0;
            r_bit_strobe <= 1'b0;
        end else begin
            r_div_cnt    <= w_div_next;
            r_pdm_clk    <= (w_div_next >= c_DIV_HALF);
            r_bit_strobe <= w_boundary;
            if (w_boundary) begin
                r_pdm_out <= w_sum[16];
                r_acc     <= w_sum[15:0];
                r_bit_cnt <= (r_bit_cnt == c_BIT_LAST) ? '0 : r_bit_cnt + c_BIT_W'(1);
            end
            if (w_load) begin
                r_active    <= w_next_active;
                r_hold_full <= 1'b0;
            end
            // A capture in the load cycle refills the hold for the following frame.
            if (w_accept) begin
                r_hold      <= sample_in;
                r_hold_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_underrun_count <= '0;
        else if (w_underrun && (r_underrun_count != 16'hFFFF))
            r_underrun_count <= r_underrun_count + 16'd1;
    end

    assign sample_ready   = w_ready;
    assign pdm_clk        = r_pdm_clk;
    assign pdm_out        = r_pdm_out;
    assign bit_strobe     = r_bit_strobe;
    assign frame_strobe   = w_load;
    assign underrun       = w_underrun;
    assign underrun_count = r_underrun_count;

endmodule
`default_nettype wire

// File: tb/tb_pdm_modulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_pdm_modulator
// Function : Directed self-checking bench for pdm_modulator (CLK_DIV=4, OSR=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pdm_modulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] sample_in = 16'd0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        pdm_clk;
    logic        pdm_out;
    logic        bit_strobe;
    logic        frame_strobe;
    logic        underrun;
    logic [15:0] underrun_count;
    logic [31:0] w_outs;

    int n_chk = 0;
    int n_bad = 0;

    // Per-window observations, a window running up to and including a frame_strobe.
    logic [7:0]  win_bits;
    logic [31:0] win_clk;
    int          win_nbits;
    int          win_ncyc;
    int          win_ready_hi;
    int          win_under;
    int          win_viol;
    logic        win_first_bs;
    logic        win_done;

    pdm_modulator #(.CLK_DIV(4), .OSR(8)) u_dut (
        .clk            (clk),
        .reset          (rst),
        .en             (en),
        .sample_in      (sample_in),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .pdm_clk        (pdm_clk),
        .pdm_out        (pdm_out),
        .bit_strobe     (bit_strobe),
        .frame_strobe   (frame_strobe),
        .underrun       (underrun),
        .underrun_count (underrun_count)
    );

    assign w_outs = {10'd0, pdm_clk, pdm_out, bit_strobe, frame_strobe,
                     underrun, sample_ready, underrun_count};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_win(input bit one_shot);
        logic prev;
        win_bits     = '0;
        win_clk      = '0;
        win_nbits    = 0;
        win_ncyc     = 0;
        win_ready_hi = 0;
        win_under    = 0;
        win_viol     = 0;
        win_first_bs = 1'b0;
        win_done     = 1'b0;
        prev         = pdm_out;
        for (int i = 0; i < 40 && !win_done; i++) begin
            tick();
            win_ncyc++;
            if (i == 0) win_first_bs = bit_strobe;
            win_clk = {win_clk[30:0], pdm_clk};
            if (bit_strobe) begin
                win_bits = {win_bits[6:0], pdm_out};
                win_nbits++;
            end
            if ((pdm_out !== prev) && !bit_strobe) win_viol++;
            prev = pdm_out;
            if (sample_ready) win_ready_hi++;
            if (underrun) win_under++;
            if (one_shot && i == 1) sample_valid = 1'b0;
            if (frame_strobe) win_done = 1'b1;
        end
        chk("frame_timeout", {31'd0, win_done}, 32'd1);
    endtask

    task automatic expect_win(input string tag, input logic [7:0] bits, input int nbits,
                              input int under, input int ready_hi, input int ncyc);
        chk({tag, ".bits"}, {24'd0, win_bits}, {24'd0, bits});
        chk({tag, ".nbits"}, win_nbits, nbits);
        chk({tag, ".underrun"}, win_under, under);
        chk({tag, ".ready"}, win_ready_hi, ready_hi);
        chk({tag, ".cycles"}, win_ncyc, ncyc);
        chk({tag, ".stable"}, win_viol, 0);
        if (ncyc == 32) chk({tag, ".pdm_clk"}, win_clk, 32'h3333_3333);
    endtask

    initial begin
        tick();
        chk("reset_outs", w_outs, 32'd0);
        rst = 1'b0;
        sample_valid = 1'b1;
        sample_in = 16'h1234;
        repeat (3) begin
            tick();
            chk("idle_outs", w_outs, 32'd0);
        end

        // Midscale: 7 prime bits, then frames of 0 starting from acc=0x8000.
        sample_in = 16'h0000;
        en = 1'b1;
        run_win(1'b0); expect_win("prime", 8'h2A, 7, 0, 1, 32);
        run_win(1'b0); expect_win("mid1", 8'hAA, 8, 0, 1, 32);
        sample_in = 16'h9000;
        run_win(1'b0); expect_win("mid2", 8'hAA, 8, 0, 1, 32);
        // 0x9000 adds 8*0x1000 and returns acc to 0 for the full-scale runs.
        sample_in = 16'h8000;
        run_win(1'b0); expect_win("s9000", 8'h01, 8, 0, 1, 32);
        run_win(1'b0); expect_win("neg1", 8'h00, 8, 0, 1, 32);
        sample_in = 16'h7FFF;
        run_win(1'b0); expect_win("neg2", 8'h00, 8, 0, 1, 32);
        run_win(1'b0); expect_win("pos1", 8'h7F, 8, 0, 1, 32);
        run_win(1'b0); expect_win("pos2", 8'hFF, 8, 0, 1, 32);
        chk("count_run", {16'd0, underrun_count}, 32'd0);

        // en drop mid-frame with hold full.
        repeat (5) tick();
        chk("hold_full", {31'd0, sample_ready}, 32'd0);
        en = 1'b0;
        tick();
        chk("en_drop", {26'd0, pdm_out, pdm_clk, sample_ready, bit_strobe, frame_strobe, underrun}, 32'd0);
        sample_valid = 1'b0;
        en = 1'b1;
        run_win(1'b0); expect_win("reprime", 8'h2A, 7, 0, 32, 32);

        // Handshake: 100 accepted at once, 200 waits for the frame load.
        sample_valid = 1'b1;
        sample_in = 16'd100;
        chk("hs_ready_a", {31'd0, sample_ready}, 32'd1);
        tick();
        chk("hs_ready_b", {31'd0, sample_ready}, 32'd0);
        sample_in = 16'd200;
        run_win(1'b0); expect_win("hs_wait", 8'h2A, 7, 0, 0, 31);
        run_win(1'b1);
        chk("hs_first_bit", {31'd0, win_first_bs}, 32'd1);
        expect_win("hs_100", 8'hAA, 8, 0, 1, 32);
        run_win(1'b0); expect_win("hs_200", 8'hAA, 8, 1, 32, 32);
        chk("ur_count0", {16'd0, underrun_count}, 32'd0);

        // Underrun, then a valid arriving in the frame-load cycle.
        run_win(1'b0); expect_win("ur_a", 8'hAA, 8, 1, 32, 32);
        chk("ur_count1", {16'd0, underrun_count}, 32'd1);
        sample_valid = 1'b1;
        sample_in = 16'h9000;
        run_win(1'b1); expect_win("ur_b", 8'hAA, 8, 0, 0, 32);
        chk("ur_count2", {16'd0, underrun_count}, 32'd2);
        run_win(1'b0); expect_win("ur_cap", 8'h01, 8, 1, 32, 32);
        chk("ur_count2b", {16'd0, underrun_count}, 32'd2);

        // Asynchronous reset between clock edges.
        repeat (6) tick();
        chk("ur_count3", {16'd0, underrun_count}, 32'd3);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst", w_outs, 32'd0);
        en = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        sample_valid = 1'b1;
        sample_in = 16'h4321;
        repeat (3) begin
            tick();
            chk("idle_after_rst", w_outs, 32'd0);
        end
        sample_valid = 1'b0;
        en = 1'b1;
        run_win(1'b0); expect_win("post_rst", 8'h2A, 7, 0, 32, 32);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pdm_modulator.md
# pdm_modulator

First-order sigma-delta PDM transmitter, the output-side counterpart of the microphone PDM receive path. It accepts signed 16-bit PCM samples through a valid/ready handshake, buffers one sample ahead, and serialises each sample as OSR PDM bits on pdm_out. It also generates the matching pdm_clk. It sits between the sample-processing logic and the board audio/PDM output pin, on the same system clock as the receive path.

## Interface
- CLK_DIV, 32: clk cycles per PDM bit; even, ≥ 4 (100 MHz / 32 = 3.125 MHz PDM).
- OSR, 32: PDM bits per PCM sample; ≥ 2.
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active high.
- en  in  1  run enable; low returns block to IDLE.
- sample_in  in  16  signed PCM sample, two's complement.
- sample_valid  in  1  sample_in valid this cycle.
- sample_ready  out  1  hold register empty; a transfer occurs when valid && ready.
- pdm_clk  out  1  PDM bit clock; 50% duty.
- pdm_out  out  1  PDM data; changes only on pdm_clk falling edges.
- bit_strobe  out  1  one-cycle pulse on each pdm_out update.
- frame_strobe  out  1  one-cycle pulse on each sample load into the modulator.
- underrun  out  1  one-cycle pulse when a frame load finds hold empty in RUN.
- underrun_count  out  16  saturating count of underrun pulses; cleared only by reset.

## Operation
- Reset values: all outputs 0, including sample_ready. State IDLE. Counters, accumulator, active and hold registers are 0.
- **States**
  - IDLE (en=0): all outputs 0 except underrun_count. div_cnt, bit_cnt, acc, active and hold are cleared. Input handshake is ignored.
  - IDLE→PRIME: on en=1.
  - PRIME: modulates active=0 (midscale). No underrun is reported.
  - PRIME→RUN: at the first frame load that finds hold full.
  - RUN: on every frame load, active←hold. If hold is empty, active←0, underrun pulses and underrun_count increments (saturating at 16'hFFFF).
  - Any state→IDLE: on en=0, on the next clk edge.
- **Handshake**
  - sample_ready = (state≠IDLE) && !hold_full.
  - On valid && ready, hold←sample_in and hold_full←1.
  - A frame load clears hold_full. sample_ready rises the cycle after frame_strobe.
  - If valid arrives in the frame-load cycle while hold is empty, the load sees empty (underrun in RUN). The incoming sample is captured into hold. There is no bypass.
- **Bit timing**
  - div_cnt runs 0..CLK_DIV-1 and wraps.
  - pdm_clk is registered: 0 while div_cnt < CLK_DIV/2, 1 otherwise.
  - A bit boundary is the cycle div_cnt wraps to 0. On it: pdm_out←carry, acc updates, bit_strobe pulses, bit_cnt increments mod OSR.
- **Modulator**
  - u = {~active[15], active[14:0]} (16-bit offset binary).
  - {carry, acc[15:0]} = acc + u (17-bit sum). Only acc[15:0] is kept.
  - Ones density over 65536 bits is exactly u/65536.
  - acc persists across frames and clears only in IDLE/reset.
- **Frame load**
  - Occurs in the cycle div_cnt==CLK_DIV-1 && bit_cnt==OSR-1; frame_strobe pulses in that cycle.
  - The new active value drives the very next bit boundary.
  - The first frame load after en rises comes after OSR bits.

## Timing
- pdm_clk period is CLK_DIV clk cycles.
- pdm_out is stable from one falling edge to the next, so it is valid at the pdm_clk rising edge.
- Input-to-output latency: from a sample entering an empty hold to its first PDM bit is at most OSR·CLK_DIV+1 cycles; the first bit follows frame_strobe by 1 cycle.
- Sustained throughput: one sample per OSR·CLK_DIV cycles. sample_ready stays low between acceptance and the next frame load.
- Asynchronous reset mid-frame: all outputs drop to 0 immediately. After release, the block stays in IDLE until en is seen high on a clk edge.
- en low mid-frame: the partial frame is discarded and the hold sample is dropped. No underrun is reported.

## Test plan
(CLK_DIV=4, OSR=8 for all)
- **Reset/idle:** assert reset mid-run; then hold en=0 with sample_valid=1 -> all outputs 0, sample_ready 0, underrun_count 0, no capture.
- **Midscale:**
  - Stimulus: en=1, present sample 0 once, then keep hold full with 0.
  - pdm_clk: period 4 cycles, high 2.
  - pdm_out: 0,1,0,1… at every bit_strobe; 4 ones per 8-bit frame.
  - underrun: stays 0.
- **Full scale:** feed -32768 continuously -> pdm_out stays 0 after the first load. Then feed 32767 continuously -> pdm_out is 1 on every bit except the first bit after the switch.
- **Handshake:**
  - Stimulus: assert valid with values 100 then 200 back to back.
  - 100: accepted immediately; sample_ready drops.
  - 200: held until the cycle after frame_strobe, then accepted.
  - 100 drives bits 1-8 after that frame_strobe.
- **Underrun:**
  - Stimulus: load one sample, then stop.
  - At the next frame_strobe: underrun pulses exactly 1 cycle, underrun_count=1, output returns to the 0,1 pattern.
  - A valid in the frame-load cycle: still counts as an underrun and is captured for the following frame.
- **en drop:** deassert en mid-frame with hold full -> next cycle pdm_out, pdm_clk, sample_ready are 0. After re-enable, the state is PRIME and the first frame_strobe comes after 32 cycles.
